// File: rtl/dmem_responder.sv
// Single-port data memory for the core's load/store path.
// Optional post-reset zero-fill gates oReady.
module dmem_responder #(
  parameter int CACHE_WIDTHE   = 5,
  parameter int CACHE_DEEPTHE  = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         iCen,
  input  logic                         iWrEn,
  input  logic [CACHE_DEEPTHE-1:0]     iAddr,
  input  logic [2**CACHE_WIDTHE-1:0]   iWrMask,
  input  logic [2**CACHE_WIDTHE-1:0]   iWrData,
  output logic [2**CACHE_WIDTHE-1:0]   oMemData,
  output logic                         oReady
);

  localparam int W = 2**CACHE_WIDTHE;
  localparam int D = 2**CACHE_DEEPTHE;

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  localparam state_t RST_STATE =
    CLEAR_ON_RESET ? INIT : IDLE;

  state_t state;
  state_t stateNext;

  logic [CACHE_DEEPTHE-1:0] ptr;
  logic [CACHE_DEEPTHE-1:0] ptrNext;

  logic [W-1:0] mem [D];

  logic                     memWe;
  logic                     rdEn;
  logic [CACHE_DEEPTHE-1:0] memAddr;
  logic [W-1:0]             memMask;
  logic [W-1:0]             memWdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RST_STATE;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    memWe     = 1'b0;
    rdEn      = 1'b0;
    memAddr   = iAddr;
    memMask   = iWrMask;
    memWdata  = iWrData;
    unique case (state)
      INIT: begin
        // Requests are ignored while the sequencer owns the port
        memWe    = 1'b1;
        memAddr  = ptr;
        memMask  = '1;
        memWdata = '0;
        ptrNext  = ptr + 1'b1;
        if (&ptr) stateNext = IDLE;
      end
      IDLE: begin
        if (!iCen) begin
          if (iWrEn) memWe = 1'b1;
          else       rdEn  = 1'b1;
        end
      end
      default: stateNext = RST_STATE;
    endcase
  end

  // Array has no reset; only the sequencer clears it
  always_ff @(posedge clk) begin
    if (memWe)
      mem[memAddr] <= (mem[memAddr] & ~memMask)
                    | (memWdata & memMask);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     oMemData <= '0;
    else if (rdEn) oMemData <= mem[iAddr];
  end

  assign oReady = (state == IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: clear
// sequencing, masked writes, holds and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rstn;
  logic        iCen;
  logic        iWrEn;
  logic [11:0] iAddr;
  logic [31:0] iWrMask;
  logic [31:0] iWrData;
  logic [31:0] oMemData;
  logic        oReady;

  logic        rstn2;
  logic        cen2;
  logic        wrEn2;
  logic [11:0] addr2;
  logic [31:0] mask2;
  logic [31:0] wdata2;
  logic [31:0] memData2;
  logic        ready2;

  int compared;
  int mismatched;
  int cnt;

  dmem_responder dut (
    .clk      (clk),
    .rstn     (rstn),
    .iCen     (iCen),
    .iWrEn    (iWrEn),
    .iAddr    (iAddr),
    .iWrMask  (iWrMask),
    .iWrData  (iWrData),
    .oMemData (oMemData),
    .oReady   (oReady)
  );

  dmem_responder #(
    .CLEAR_ON_RESET (1'b0)
  ) dutNc (
    .clk      (clk),
    .rstn     (rstn2),
    .iCen     (cen2),
    .iWrEn    (wrEn2),
    .iAddr    (addr2),
    .iWrMask  (mask2),
    .iWrData  (wdata2),
    .oMemData (memData2),
    .oReady   (ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic req(
    input logic        cen,
    input logic        wr,
    input logic [11:0] a,
    input logic [31:0] m,
    input logic [31:0] d
  );
    iCen    = cen;
    iWrEn   = wr;
    iAddr   = a;
    iWrMask = m;
    iWrData = d;
  endtask

  task automatic waitReady(input string tag);
    cnt = 0;
    while (!oReady && cnt < 5000) begin
      step();
      cnt++;
    end
    check(tag, 32'(cnt), 32'd4096);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rstn   = 1'b0;
    rstn2  = 1'b0;
    req(1'b1, 1'b0, 12'h000, 32'h0, 32'h0);
    cen2   = 1'b1;
    wrEn2  = 1'b0;
    addr2  = 12'h000;
    mask2  = 32'h0;
    wdata2 = 32'h0;
    #1;
    repeat (2) step();
    check("rst_ready", 32'(oReady), 32'd0);
    check("rst_data", oMemData, 32'h0);
    check("nc_rst_ready", 32'(ready2), 32'd1);
    check("nc_rst_data", memData2, 32'h0);

    // write held throughout clear must be ignored
    req(1'b0, 1'b1, 12'h010, 32'hFFFFFFFF,
        32'hFFFFFFFF);
    rstn  = 1'b1;
    rstn2 = 1'b1;
    waitReady("clear_len");
    check("clear_data", oMemData, 32'h0);
    req(1'b0, 1'b0, 12'h010, 32'h0, 32'h0);
    step();
    check("init_wr_ignored", oMemData, 32'h0);

    req(1'b0, 1'b1, 12'hFFF, 32'hFFFFFFFF,
        32'hDEADBEEF);
    step();
    check("wr_no_rd", oMemData, 32'h0);
    req(1'b0, 1'b0, 12'hFFF, 32'h0, 32'h0);
    step();
    check("rd_fff", oMemData, 32'hDEADBEEF);

    req(1'b0, 1'b1, 12'h123, 32'hFFFFFFFF,
        32'hAAAAAAAA);
    step();
    req(1'b0, 1'b1, 12'h123, 32'h0000FFFF,
        32'h12345678);
    step();
    check("wr_hold", oMemData, 32'hDEADBEEF);
    req(1'b0, 1'b0, 12'h123, 32'h0, 32'h0);
    step();
    check("rd_merge", oMemData, 32'hAAAA5678);

    req(1'b1, 1'b0, 12'h123, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("cen_hold", oMemData, 32'hAAAA5678);
    end
    req(1'b0, 1'b1, 12'h123, 32'hFFFFFFFF,
        32'h0BADF00D);
    step();
    check("wr_after_hold", oMemData, 32'hAAAA5678);
    req(1'b0, 1'b1, 12'h123, 32'h0, 32'hFFFFFFFF);
    step();
    req(1'b0, 1'b0, 12'h123, 32'h0, 32'h0);
    step();
    check("rd_zero_mask", oMemData, 32'h0BADF00D);

    cen2   = 1'b0;
    wrEn2  = 1'b1;
    addr2  = 12'h001;
    mask2  = 32'hFFFFFFFF;
    wdata2 = 32'h5A5A5A5A;
    step();
    cen2  = 1'b1;
    rstn2 = 1'b0;
    #1;
    check("nc_ready_in_rst", 32'(ready2), 32'd1);
    step();
    rstn2 = 1'b1;
    cen2  = 1'b0;
    wrEn2 = 1'b0;
    step();
    check("nc_retained", memData2, 32'h5A5A5A5A);
    check("nc_ready", 32'(ready2), 32'd1);

    req(1'b1, 1'b0, 12'h000, 32'h0, 32'h0);
    rstn = 1'b0;
    #1;
    check("async_rst_data", oMemData, 32'h0);
    check("async_rst_ready", 32'(oReady), 32'd0);
    step();
    rstn = 1'b1;
    repeat (2048) step();
    check("mid_init_ready", 32'(oReady), 32'd0);
    rstn = 1'b0;
    #1;
    step();
    rstn = 1'b1;
    waitReady("restart_len");

    req(1'b0, 1'b0, 12'h123, 32'h0, 32'h0);
    step();
    check("cleared_123", oMemData, 32'h0);
    req(1'b0, 1'b0, 12'hFFF, 32'h0, 32'h0);
    step();
    check("cleared_fff", oMemData, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
